// File: rtl/lfsr_pattern_ctrl.sv
// lfsr_pattern_ctrl
//   BIST sequencer. An accepted start seeds a right-shifting LFSR (taps at
//   bits 1 and 0). The sequencer then streams N patterns over a valid/ready
//   handshake and compacts the returned responses into a MISR. The final
//   signature is compared against a latched golden value.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   start, abort        run control (start only in IDLE, abort in RUN/DRAIN)
//   seed, num_patterns, golden   run setup, latched on accepted start
//   pat_valid/pat_ready/pat_data    pattern stream to the unit under test
//   resp_valid/resp_ready/resp_data response stream back from it
//   busy                high in RUN or DRAIN
//   done                one-cycle end-of-run pulse
//   pass, signature     result, held until the next accepted start
module lfsr_pattern_ctrl #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [WIDTH-1:0] golden,
    output logic             pat_valid,
    input  logic             pat_ready,
    output logic [WIDTH-1:0] pat_data,
    input  logic             resp_valid,
    output logic             resp_ready,
    input  logic [WIDTH-1:0] resp_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // All-zero is the LFSR lock-up state; substitute a known non-zero seed.
    localparam logic [WIDTH-1:0] SEED_FIX = WIDTH'(64'h0000_0000_0000_0202);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, misr_q, golden_q, signature_q;
    logic [CNT_W-1:0] sent_q, rcvd_q, n_q;
    logic             pass_q;

    logic             start_acc, active, pat_hs, resp_acc;
    logic [CNT_W-1:0] sent_nx, rcvd_nx;
    logic [WIDTH-1:0] lfsr_step, misr_nx, misr_fin;

    assign start_acc = (state_q == IDLE) && start;
    assign active    = (state_q == RUN) || (state_q == DRAIN);
    assign pat_valid = (state_q == RUN) && (sent_q < n_q);
    assign pat_hs    = pat_valid && pat_ready;
    // Responses beyond the N-th are taken off the bus but not compacted.
    assign resp_acc  = active && resp_valid && (rcvd_q < n_q);
    assign sent_nx   = sent_q + CNT_W'(pat_hs);
    assign rcvd_nx   = rcvd_q + CNT_W'(resp_acc);

    assign lfsr_step = {lfsr_q[1] ^ lfsr_q[0], lfsr_q[WIDTH-1:1]};
    assign misr_nx   = {misr_q[1] ^ misr_q[0], misr_q[WIDTH-1:1]} ^ resp_data;
    // Final signature must include a response accepted on the closing edge.
    assign misr_fin  = resp_acc ? misr_nx : misr_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = (num_patterns == '0) ? DONE : RUN;
            RUN: begin
                if (abort)
                    state_d = IDLE;
                else if (pat_hs && (sent_nx == n_q))
                    state_d = (rcvd_nx == n_q) ? DONE : DRAIN;
            end
            DRAIN: begin
                if (abort)
                    state_d = IDLE;
                else if (resp_acc && (rcvd_nx == n_q))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED_FIX;
            misr_q      <= '0;
            sent_q      <= '0;
            rcvd_q      <= '0;
            n_q         <= '0;
            golden_q    <= '0;
            signature_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                lfsr_q      <= (seed == '0) ? SEED_FIX : seed;
                misr_q      <= '0;
                sent_q      <= '0;
                rcvd_q      <= '0;
                n_q         <= num_patterns;
                golden_q    <= golden;
                signature_q <= '0;
                // An empty run finishes next cycle with a zero signature.
                pass_q      <= (num_patterns == '0) && (golden == '0);
            end else begin
                if (pat_hs) begin
                    lfsr_q <= lfsr_step;
                    sent_q <= sent_nx;
                end
                if (resp_acc) begin
                    misr_q <= misr_nx;
                    rcvd_q <= rcvd_nx;
                end
                if (active && (state_d == DONE)) begin
                    signature_q <= misr_fin;
                    pass_q      <= (misr_fin == golden_q);
                end
                if (active && abort)
                    pass_q <= 1'b0;
            end
        end
    end

    assign pat_data   = lfsr_q;
    assign resp_ready = active;
    assign busy       = active;
    assign done       = (state_q == DONE);
    assign pass       = pass_q;
    assign signature  = signature_q;

endmodule

// File: tb/tb_lfsr_pattern_ctrl.sv
// Scoreboard bench for lfsr_pattern_ctrl. Expected patterns and run results
// come from a reference LFSR/MISR model. They are queued when a run is
// launched and popped as the DUT hands out patterns and done pulses.
module tb_lfsr_pattern_ctrl;

    localparam int W = 64;
    localparam int C = 16;

    logic         clk, rst, start, abort;
    logic [W-1:0] seed, golden, pat_data, resp_data, signature;
    logic [C-1:0] num_patterns;
    logic         pat_valid, pat_ready, resp_valid, resp_ready;
    logic         busy, done, pass;

    lfsr_pattern_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed),
        .num_patterns(num_patterns), .golden(golden),
        .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_data(pat_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .busy(busy), .done(done), .pass(pass), .signature(signature)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    logic [W-1:0] pat_q[$];
    logic [W:0]   done_q[$];   // {pass, signature}
    logic [W-1:0] rsp[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Output monitor: pattern/done scoreboard plus stall-hold check.
    logic         stall_q = 1'b0;
    logic [W-1:0] hold_d;
    always @(negedge clk) begin
        if (!rst) begin
            if (pat_valid) begin
                if (stall_q) chk("pat_hold", pat_data, hold_d);
                if (pat_ready) begin
                    if (pat_q.size() == 0) chk("pat_extra", 1, 0);
                    else chk("pat_data", pat_data, pat_q.pop_front());
                    stall_q = 1'b0;
                end else begin
                    stall_q = 1'b1;
                    hold_d  = pat_data;
                end
            end else begin
                stall_q = 1'b0;
            end
            if (done) begin
                if (done_q.size() == 0) chk("done_extra", 1, 0);
                else begin
                    logic [W:0] e;
                    e = done_q.pop_front();
                    chk("signature", signature, e[W-1:0]);
                    chk("pass", pass, e[W]);
                end
            end
        end
    end

    function automatic logic [W-1:0] step(input logic [W-1:0] s);
        return {s[1] ^ s[0], s[W-1:1]};
    endfunction

    task automatic run_test(input logic [W-1:0] sd, input int n, input logic [W-1:0] gd,
                            input bit stall, input bit late, input bit busy_start);
        logic [W-1:0] s, m;
        int  sent, ri, cyc;
        bit  fin, drain_seen;
        s = (sd == '0) ? 64'h202 : sd;
        for (int i = 0; i < n; i++) begin
            pat_q.push_back(s);
            s = step(s);
        end
        m = '0;
        for (int i = 0; i < n; i++) m = step(m) ^ rsp[i];
        done_q.push_back({m == gd, m});

        seed = sd; num_patterns = C'(n); golden = gd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Setup inputs are latched; scramble them to prove it.
        seed = {$urandom, $urandom}; golden = {$urandom, $urandom};
        num_patterns = C'($urandom_range(1, 9));
        sent = 0; ri = 0; cyc = 0; fin = 0; drain_seen = 0;
        while (!fin && cyc < 200) begin
            start      = busy_start && (cyc == 1);
            pat_ready  = stall ? ((cyc % 3) == 0) : 1'b1;
            resp_valid = (ri < sent) && (!late || sent >= n);
            resp_data  = (ri < n) ? rsp[ri] : {$urandom, $urandom};
            @(negedge clk);
            if (done) fin = 1;
            if (busy && !pat_valid) drain_seen = 1;
            if (pat_valid && pat_ready) sent++;
            if (resp_valid && resp_ready) ri++;
            if (!fin) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0; resp_valid = 1'b0;
        if (!fin) chk("timeout", 0, 1);
        if (n == 0) chk("n0_latency", cyc, 0);
        if (late) chk("drain_seen", drain_seen, 1);
        chk("pat_count", sent, n);
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("idle_after", busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start = 0; abort = 0; seed = '0; golden = '0; num_patterns = '0;
        pat_ready = 1'b1; resp_valid = 0; resp_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_pat_valid", pat_valid, 0);
        chk("rst_resp_ready", resp_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_signature", signature, 0);
        chk("rst_lfsr", pat_data, 64'h202);
        repeat (2) @(negedge clk);
        chk("idle_pat_valid", pat_valid, 0);
        @(posedge clk); #1;

        // Free-running sequence from seed 1.
        rsp = '{64'h11, 64'h22, 64'h33};
        run_test(64'h1, 3, 64'h0, 0, 0, 0);

        // MISR golden pass, then the same run with a wrong golden.
        rsp = '{64'h1, 64'h0};
        run_test(64'h1234_5678_9abc_def0, 2, 64'h8000_0000_0000_0000, 0, 0, 0);
        run_test(64'h1234_5678_9abc_def0, 2, 64'h0, 0, 0, 0);

        // Zero seed substitution, then an empty run.
        rsp = '{64'h77};
        run_test(64'h0, 1, 64'h77, 0, 0, 0);
        rsp = {};
        run_test(64'h5, 0, 64'h0, 0, 0, 0);

        // Stalled consumer with responses held back until all patterns leave.
        rsp = '{64'hdead, 64'hbeef, 64'hcafe, 64'hf00d};
        run_test(64'h1, 4, 64'h0, 1, 1, 0);

        // Abort on the second pattern.
        pat_q.push_back(64'h1);
        pat_q.push_back(64'h8000_0000_0000_0000);
        seed = 64'h1; num_patterns = 16'd4; golden = '0; start = 1'b1; pat_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 abort = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_pat_valid", pat_valid, 0);
        chk("abort_pass", pass, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        chk("abort_done2", done, 0);
        @(posedge clk); #1;

        // Fresh run after abort, with a start pulse while busy.
        rsp = '{64'hA5};
        run_test(64'h9, 1, 64'hA5, 0, 0, 1);

        // Longer random run.
        rsp = {};
        for (int i = 0; i < 20; i++) rsp.push_back({$urandom, $urandom});
        run_test({$urandom, $urandom}, 20, {$urandom, $urandom}, 1, 0, 0);

        chk("pat_q_empty", pat_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
